// File: rtl/block_memory.sv
// Block-granular backing store below the cache: serves 4-word block reads and
// writes after a fixed access latency, one request outstanding at a time.
module block_memory #(
    parameter int WORD_SIZE = 16,
    parameter int READ_SIZE = 64,
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [READ_SIZE-1:0] dataM,
    output logic                 readyM,
    output logic                 input_readyM,
    output logic                 doneM,
    output logic [WORD_SIZE-1:0] num_reads,
    output logic [WORD_SIZE-1:0] num_writes,
    output logic [2:0]           state_o
);

    localparam int AW     = $clog2(MEM_WORDS);
    localparam int BLOCKS = MEM_WORDS / 4;
    localparam int IDX_W  = (AW > 2) ? AW - 2 : 1;
    localparam bit LAT1   = (LATENCY == 1);
    localparam logic [7:0]           CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;
    localparam logic [WORD_SIZE-1:0] ONE      = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_WAIT = 3'd3,
        S_WR_RESP = 3'd4,
        S_TURN    = 3'd5
    } state_e;

    state_e               state_q;
    logic [7:0]           cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [READ_SIZE-1:0] wdata_q;
    logic [READ_SIZE-1:0] rdata_q;
    logic                 ready_q;
    logic                 in_ready_q;
    logic                 done_q;
    logic [WORD_SIZE-1:0] num_reads_q;
    logic [WORD_SIZE-1:0] num_writes_q;

    logic [READ_SIZE-1:0] mem_q [BLOCKS];

    logic [IDX_W-1:0]     addr_idx;
    logic [IDX_W-1:0]     blk_idx_d;
    logic [READ_SIZE-1:0] wr_data_d;
    logic                 rd_fire;
    logic                 wr_fire;
    logic                 unused_addr_bits;

    // Only the block-index field of the address selects storage; the rest aliases.
    if (AW > 2) begin : g_idx
        assign addr_idx = address[AW-1:2];
    end else begin : g_idx_single
        assign addr_idx = '0;
    end
    assign unused_addr_bits = ^address;

    // rd_fire / wr_fire mark the edge that enters the response cycle; with a
    // latency of one that edge is the accept edge itself, so the live bus is used.
    always_comb begin
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                rd_fire = LAT1 && readM;
                wr_fire = LAT1 && !readM && writeM;
            end
            S_RD_WAIT: rd_fire = readM && (cnt_q == 8'd0);
            S_WR_WAIT: wr_fire = writeM && (cnt_q == 8'd0);
            default: ;
        endcase
    end

    assign blk_idx_d = (state_q == S_IDLE) ? addr_idx : idx_q;
    assign wr_data_d = (state_q == S_IDLE) ? dataM : wdata_q;

    // Array has no reset; reset only blocks a commit that would coincide with it.
    always_ff @(posedge clk) begin
        if (wr_fire && !reset) begin
            mem_q[blk_idx_d] <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b1;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            num_reads_q  <= '0;
            num_writes_q <= '0;
        end else begin
            in_ready_q <= rd_fire;
            done_q     <= wr_fire;
            if (rd_fire) begin
                rdata_q     <= mem_q[blk_idx_d];
                num_reads_q <= num_reads_q + ONE;
            end
            if (wr_fire) begin
                num_writes_q <= num_writes_q + ONE;
            end
            case (state_q)
                S_IDLE: begin
                    if (readM) begin
                        idx_q   <= addr_idx;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        if (LAT1) state_q <= S_RD_RESP;
                        else      state_q <= S_RD_WAIT;
                    end else if (writeM) begin
                        idx_q   <= addr_idx;
                        wdata_q <= dataM;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        if (LAT1) state_q <= S_WR_RESP;
                        else      state_q <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (!readM) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= S_RD_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_WR_WAIT: begin
                    if (!writeM) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= S_WR_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RD_RESP: state_q <= S_TURN;
                S_WR_RESP: state_q <= S_TURN;
                S_TURN: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Bus is released in every state except the single read-response cycle.
    assign dataM        = in_ready_q ? rdata_q : {READ_SIZE{1'bz}};
    assign readyM       = ready_q;
    assign input_readyM = in_ready_q;
    assign doneM        = done_q;
    assign num_reads    = num_reads_q;
    assign num_writes   = num_writes_q;
    assign state_o      = state_q;

    a_resp_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(in_ready_q && done_q));
    a_ready_idle: assert property (@(posedge clk) disable iff (reset)
        ready_q == (state_q == S_IDLE));

endmodule

// File: tb/tb_block_memory.sv
// Randomized bench for block_memory: a block-array model plus expected-read
// queue judges a LATENCY=4 instance, a LATENCY=1 instance covers back-to-back reads.
module tb_block_memory;

    localparam int WS  = 16;
    localparam int RS  = 64;
    localparam int MW  = 256;
    localparam int LAT = 4;
    localparam int NB  = MW / 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          rd0, wr0, drv_en0;
    logic [WS-1:0] addr0;
    logic [RS-1:0] drv0;
    wire  [RS-1:0] data0;
    logic          rdy0, irdy0, done0;
    logic [WS-1:0] nr0, nw0;
    logic [2:0]    st0;
    assign data0 = drv_en0 ? drv0 : {RS{1'bz}};

    logic          rd1, wr1, drv_en1;
    logic [WS-1:0] addr1;
    logic [RS-1:0] drv1;
    wire  [RS-1:0] data1;
    logic          rdy1, irdy1, done1;
    logic [WS-1:0] nr1, nw1;
    logic [2:0]    st1;
    assign data1 = drv_en1 ? drv1 : {RS{1'bz}};

    block_memory #(.WORD_SIZE(WS), .READ_SIZE(RS), .MEM_WORDS(MW), .LATENCY(LAT)) u_dut0 (
        .clk(clk), .reset(reset), .readM(rd0), .writeM(wr0), .address(addr0),
        .dataM(data0), .readyM(rdy0), .input_readyM(irdy0), .doneM(done0),
        .num_reads(nr0), .num_writes(nw0), .state_o(st0)
    );

    block_memory #(.WORD_SIZE(WS), .READ_SIZE(RS), .MEM_WORDS(MW), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .readM(rd1), .writeM(wr1), .address(addr1),
        .dataM(data1), .readyM(rdy1), .input_readyM(irdy1), .doneM(done1),
        .num_reads(nr1), .num_writes(nw1), .state_o(st1)
    );

    // scoreboard and reference model
    int            checks   = 0;
    int            failures = 0;
    logic [RS-1:0] model_mem [NB];
    logic [RS-1:0] model1 [2];
    logic [WS-1:0] exp_reads;
    logic [WS-1:0] exp_writes;
    logic [RS-1:0] exp_q [$];

    task automatic check(input string tag, input logic [RS-1:0] got, input logic [RS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int blk(input logic [WS-1:0] a);
        return int'(a[$clog2(MW)-1:2]);
    endfunction

    function automatic logic [WS-1:0] addr_for(input int b);
        logic [WS-1:0] a;
        a = WS'($urandom);
        a[$clog2(MW)-1:2] = 6'(b);
        return a;
    endfunction

    function automatic logic [RS-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // A released bus must follow whatever the bench drives onto it.
    task automatic check_bus_free(input string tag);
        logic [RS-1:0] pat;
        pat = rand64();
        drv0 = pat;
        drv_en0 = 1'b1;
        #1;
        check(tag, data0, pat);
        drv_en0 = 1'b0;
    endtask

    // driver tasks: each starts and ends on a negedge with the DUT idle
    task automatic do_read0(input logic [WS-1:0] a, input bit with_write);
        logic [RS-1:0] exp;
        check("rd_ready", rdy0, 1);
        exp_q.push_back(model_mem[blk(a)]);
        addr0 = a; rd0 = 1'b1; wr0 = with_write; drv_en0 = with_write; drv0 = rand64();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) addr0 = WS'($urandom);
            if (k == LAT - 1) drv_en0 = 1'b0;
            check("rd_busy", rdy0, 0);
            check("rd_no_done", done0, 0);
            if (k < LAT) check("rd_early", irdy0, 0);
        end
        check("rd_pulse", irdy0, 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("rd_data", data0, exp);
        exp_reads++;
        check("rd_nreads", nr0, exp_reads);
        check("rd_nwrites", nw0, exp_writes);
        rd0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
        check("rd_turn_busy", rdy0, 0);
        check("rd_turn_pulse", irdy0, 0);
        check_bus_free("rd_turn_bus");
        @(negedge clk);
    endtask

    task automatic do_write0(input logic [WS-1:0] a, input logic [RS-1:0] d);
        check("wr_ready", rdy0, 1);
        addr0 = a; wr0 = 1'b1; rd0 = 1'b0; drv_en0 = 1'b1; drv0 = d;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                drv0 = rand64();
                addr0 = WS'($urandom);
            end
            check("wr_busy", rdy0, 0);
            check("wr_no_irdy", irdy0, 0);
            if (k < LAT) check("wr_early", done0, 0);
        end
        check("wr_done", done0, 1);
        exp_writes++;
        model_mem[blk(a)] = d;
        check("wr_nwrites", nw0, exp_writes);
        check("wr_nreads", nr0, exp_reads);
        wr0 = 1'b0; drv_en0 = 1'b0;
        @(negedge clk);
        check("wr_turn_busy", rdy0, 0);
        check("wr_turn_done", done0, 0);
        @(negedge clk);
    endtask

    task automatic do_abort0(input bit is_wr, input logic [WS-1:0] a, input int k);
        check("ab_ready", rdy0, 1);
        addr0 = a; rd0 = !is_wr; wr0 = is_wr; drv_en0 = is_wr; drv0 = rand64();
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            check("ab_busy", rdy0, 0);
            check("ab_irdy", irdy0, 0);
            check("ab_done", done0, 0);
        end
        rd0 = 1'b0; wr0 = 1'b0; drv_en0 = 1'b0;
        @(negedge clk);
        check("ab_idle", rdy0, 1);
        check("ab_irdy_after", irdy0, 0);
        check("ab_done_after", done0, 0);
        check("ab_nreads", nr0, exp_reads);
        check("ab_nwrites", nw0, exp_writes);
    endtask

    task automatic do_reset_mid0(input logic [WS-1:0] a, input int k);
        check("rm_ready", rdy0, 1);
        addr0 = a; wr0 = 1'b1; drv_en0 = 1'b1; drv0 = rand64();
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            check("rm_busy", rdy0, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        wr0 = 1'b0; drv_en0 = 1'b0;
        exp_reads = '0; exp_writes = '0;
        check("rm_ready_rst", rdy0, 1);
        check("rm_irdy_rst", irdy0, 0);
        check("rm_done_rst", done0, 0);
        check("rm_nreads_rst", nr0, exp_reads);
        check("rm_nwrites_rst", nw0, exp_writes);
        check_bus_free("rm_bus");
        reset = 1'b0;
        @(negedge clk);
        check("rm_ready_post", rdy0, 1);
    endtask

    task automatic do_write1(input logic [WS-1:0] a, input logic [RS-1:0] d);
        addr1 = a; wr1 = 1'b1; drv_en1 = 1'b1; drv1 = d;
        @(negedge clk);
        check("l1_wr_done", done1, 1);
        check("l1_wr_busy", rdy1, 0);
        model1[a[2]] = d;
        wr1 = 1'b0; drv_en1 = 1'b0;
        @(negedge clk);
        check("l1_wr_turn", done1, 0);
        @(negedge clk);
        check("l1_wr_idle", rdy1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rd0 = 0; wr0 = 0; drv_en0 = 0; addr0 = '0; drv0 = '0;
        rd1 = 0; wr1 = 0; drv_en1 = 0; addr1 = '0; drv1 = '0;
        exp_reads = '0; exp_writes = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy0, 1);
        check("rst_irdy", irdy0, 0);
        check("rst_done", done0, 0);
        check("rst_nreads", nr0, 0);
        check("rst_nwrites", nw0, 0);
        check_bus_free("rst_bus");
        reset = 1'b0;
        @(negedge clk);

        // fill the array, preloading block 5 with the reference pattern
        for (int b = 0; b < NB; b++) begin
            if (b == 5) do_write0(addr_for(b), 64'h4444_3333_2222_1111);
            else        do_write0(addr_for(b), rand64());
        end

        // reset clears counters but keeps the array
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_reads = '0; exp_writes = '0;
        @(negedge clk);
        check("rst2_nwrites", nw0, 0);

        do_read0(16'h0016, 1'b0);
        check("t1_nreads", nr0, 1);
        do_write0(16'h0020, 64'hDEAD_BEEF_CAFE_F00D);
        do_read0(16'h0023, 1'b0);
        check("t2_nwrites", nw0, 1);
        do_read0(16'h0008, 1'b1);
        do_read0(16'h0008, 1'b0);
        check("t3_nwrites", nw0, 1);
        do_abort0(1'b1, 16'h0030, 2);
        do_read0(16'h0030, 1'b0);
        do_reset_mid0(16'h0040, 2);
        do_read0(16'h0040, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int b;
            b = int'($urandom_range(0, NB - 1));
            case ($urandom_range(0, 4))
                0: do_read0(addr_for(b), 1'b0);
                1: do_write0(addr_for(b), rand64());
                2: do_read0(addr_for(b), 1'b1);
                3: do_abort0(1'b0, addr_for(b), int'($urandom_range(1, LAT - 1)));
                default: do_abort0(1'b1, addr_for(b), int'($urandom_range(1, LAT - 1)));
            endcase
        end

        // LATENCY=1 instance: back-to-back reads with the request held high
        do_write1(16'h0000, rand64());
        do_write1(16'h0004, rand64());
        addr1 = 16'h0000; rd1 = 1'b1;
        @(negedge clk);
        check("l1_rd0_pulse", irdy1, 1);
        check("l1_rd0_data", data1, model1[0]);
        addr1 = 16'h0004;
        @(negedge clk);
        check("l1_turn_pulse", irdy1, 0);
        check("l1_turn_busy", rdy1, 0);
        @(negedge clk);
        check("l1_idle_pulse", irdy1, 0);
        check("l1_idle_ready", rdy1, 1);
        @(negedge clk);
        check("l1_rd1_pulse", irdy1, 1);
        check("l1_rd1_data", data1, model1[1]);
        check("l1_nreads", nr1, 2);
        rd1 = 1'b0;
        repeat (2) @(negedge clk);
        check("l1_end_ready", rdy1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
